// File: rtl/pdp_mc_controller.sv
// Multicycle control unit for the PDP-style accumulator processor: fetch, decode,
// chained indirect, execute, run/halt and a sticky fault on illegal op, deep indirection or memory timeout.
module pdp_mc_controller #(
    parameter int OPW        = 3,
    parameter int IND_LEVELS = 1,
    parameter int WAIT_MAX   = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic           i_bit,
    input  logic           ind_chain,
    input  logic           hlt_bit,
    input  logic           mem_ready,
    output logic           mem_read,
    output logic           mem_write,
    output logic [1:0]     mem_src,
    output logic           ld_ir,
    output logic           ld_ea,
    output logic           ea_src,
    output logic           ld_mdr,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_fnc,
    output logic           ld_pc,
    output logic [1:0]     pc_src,
    output logic           ld_pc_cond,
    output logic           ld_acc,
    output logic           ld_cy,
    output logic           clr_acc,
    output logic [1:0]     write_src,
    output logic           busy,
    output logic           halted,
    output logic           fault
);

    localparam int DW  = (IND_LEVELS < 1) ? 1 : $clog2(IND_LEVELS + 1);
    localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IND, S_EXEC1, S_EXEC2, S_HALT, S_FAULT
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_src;
        logic       ld_ir;
        logic       ld_ea;
        logic       ea_src;
        logic       ld_mdr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_fnc;
        logic       ld_pc;
        logic [1:0] pc_src;
        logic       ld_pc_cond;
        logic       ld_acc;
        logic       ld_cy;
        logic       clr_acc;
        logic [1:0] write_src;
        logic       busy;
        logic       halted;
        logic       fault;
    } ctl_t;

    state_t         state_r, state_s;
    logic [DW-1:0]  depth_r, depth_s;
    logic [WCW-1:0] wait_cnt_r, wait_cnt_s;
    logic [2:0]     op_q_r, op_q_s;
    logic           mem_acc_s;
    logic           illegal_s;
    logic [2:0]     op_lo_s;
    ctl_t           ctl_s, out_s;

    assign op_lo_s = op[2:0];

    if (OPW > 3) begin : g_wide_op
        assign illegal_s = |op[OPW-1:3];
    end else begin : g_narrow_op
        assign illegal_s = 1'b0;
    end

    // State, indirect depth, wait counter and latched opcode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            depth_r    <= '0;
            wait_cnt_r <= '0;
            op_q_r     <= 3'd0;
        end else begin
            state_r    <= state_s;
            depth_r    <= depth_s;
            wait_cnt_r <= wait_cnt_s;
            op_q_r     <= op_q_s;
        end
    end

    // Next-state and control decode; ld_* strobes tied to a memory access fire only on the ready cycle
    always_comb begin
        state_s   = state_r;
        depth_s   = depth_r;
        op_q_s    = op_q_r;
        mem_acc_s = 1'b0;
        ctl_s     = '0;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_FETCH;
                else       state_s = S_IDLE;
            end
            S_FETCH: begin
                ctl_s.mem_read = 1'b1;
                ctl_s.mem_src  = 2'b00;
                mem_acc_s      = 1'b1;
                if (mem_ready) begin
                    ctl_s.ld_ir = 1'b1;
                    state_s     = S_DECODE;
                end else begin
                    state_s     = S_FETCH;
                end
            end
            S_DECODE: begin
                ctl_s.ld_pc  = 1'b1;
                ctl_s.pc_src = 2'b00;
                ctl_s.ld_ea  = 1'b1;
                ctl_s.ea_src = 1'b0;
                op_q_s       = op_lo_s;
                if (illegal_s) begin
                    state_s = S_FAULT;
                end else if (i_bit && (op_lo_s <= OP_JMP)) begin
                    state_s = S_IND;
                    depth_s = DW'(1);
                end else if (op_lo_s == OP_IOT) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_EXEC1;
                end
            end
            S_IND: begin
                ctl_s.mem_read = 1'b1;
                ctl_s.mem_src  = 2'b01;
                mem_acc_s      = 1'b1;
                if (mem_ready) begin
                    ctl_s.ld_ea  = 1'b1;
                    ctl_s.ea_src = 1'b1;
                    if (!ind_chain)                  state_s = S_EXEC1;
                    else if (depth_r < DW'(IND_LEVELS)) depth_s = depth_r + DW'(1);
                    else                             state_s = S_FAULT;
                end else begin
                    state_s = S_IND;
                end
            end
            S_EXEC1: begin
                case (op_q_r)
                    OP_AND, OP_TAD: begin
                        ctl_s.mem_read = 1'b1;
                        ctl_s.mem_src  = 2'b01;
                        ctl_s.alu_fnc  = (op_q_r == OP_TAD) ? 2'b01 : 2'b00;
                        mem_acc_s      = 1'b1;
                        if (mem_ready) begin
                            ctl_s.ld_acc = 1'b1;
                            ctl_s.ld_cy  = (op_q_r == OP_TAD);
                            state_s      = S_FETCH;
                        end else begin
                            state_s      = S_EXEC1;
                        end
                    end
                    OP_ISZ: begin
                        ctl_s.mem_read = 1'b1;
                        ctl_s.mem_src  = 2'b01;
                        mem_acc_s      = 1'b1;
                        if (mem_ready) begin
                            ctl_s.ld_mdr = 1'b1;
                            state_s      = S_EXEC2;
                        end else begin
                            state_s      = S_EXEC1;
                        end
                    end
                    OP_DCA, OP_JMS: begin
                        ctl_s.mem_write = 1'b1;
                        ctl_s.mem_src   = 2'b01;
                        ctl_s.write_src = (op_q_r == OP_JMS) ? 2'b01 : 2'b00;
                        mem_acc_s       = 1'b1;
                        if (mem_ready) begin
                            ctl_s.clr_acc = (op_q_r == OP_DCA);
                            state_s       = (op_q_r == OP_JMS) ? S_EXEC2 : S_FETCH;
                        end else begin
                            state_s       = S_EXEC1;
                        end
                    end
                    OP_JMP: begin
                        ctl_s.ld_pc  = 1'b1;
                        ctl_s.pc_src = 2'b01;
                        state_s      = S_FETCH;
                    end
                    OP_OPR: begin
                        ctl_s.ld_acc  = 1'b1;
                        ctl_s.alu_fnc = 2'b11;
                        if (hlt_bit) state_s = S_HALT;
                        else         state_s = S_FETCH;
                    end
                    default: state_s = S_FETCH;
                endcase
            end
            S_EXEC2: begin
                case (op_q_r)
                    OP_ISZ: begin
                        ctl_s.mem_write = 1'b1;
                        ctl_s.mem_src   = 2'b01;
                        ctl_s.write_src = 2'b10;
                        ctl_s.alu_fnc   = 2'b10;
                        mem_acc_s       = 1'b1;
                        if (mem_ready) begin
                            ctl_s.ld_pc_cond = 1'b1;
                            state_s          = S_FETCH;
                        end else begin
                            state_s          = S_EXEC2;
                        end
                    end
                    OP_JMS: begin
                        ctl_s.ld_pc  = 1'b1;
                        ctl_s.pc_src = 2'b10;
                        state_s      = S_FETCH;
                    end
                    default: state_s = S_FETCH;
                endcase
            end
            S_HALT: begin
                ctl_s.halted = 1'b1;
                if (start) state_s = S_FETCH;
                else       state_s = S_HALT;
            end
            S_FAULT: begin
                ctl_s.fault = 1'b1;
                state_s     = S_FAULT;
            end
            default: state_s = S_FAULT;
        endcase

        // A stalled access times out after WAIT_MAX idle cycles; a ready on the last cycle still completes
        if (mem_acc_s && !mem_ready) begin
            if (wait_cnt_r == WCW'(WAIT_MAX)) begin
                state_s    = S_FAULT;
                wait_cnt_s = '0;
            end else begin
                wait_cnt_s = wait_cnt_r + WCW'(1);
            end
        end else begin
            wait_cnt_s = '0;
        end

        ctl_s.busy = (state_r != S_IDLE) && (state_r != S_HALT) && (state_r != S_FAULT);
    end

    // Reset forces every strobe low immediately, cancelling any in-flight access
    always_comb begin
        if (rst) out_s = '0;
        else     out_s = ctl_s;
    end

    assign mem_read   = out_s.mem_read;
    assign mem_write  = out_s.mem_write;
    assign mem_src    = out_s.mem_src;
    assign ld_ir      = out_s.ld_ir;
    assign ld_ea      = out_s.ld_ea;
    assign ea_src     = out_s.ea_src;
    assign ld_mdr     = out_s.ld_mdr;
    assign alu_src_a  = out_s.alu_src_a;
    assign alu_src_b  = out_s.alu_src_b;
    assign alu_fnc    = out_s.alu_fnc;
    assign ld_pc      = out_s.ld_pc;
    assign pc_src     = out_s.pc_src;
    assign ld_pc_cond = out_s.ld_pc_cond;
    assign ld_acc     = out_s.ld_acc;
    assign ld_cy      = out_s.ld_cy;
    assign clr_acc    = out_s.clr_acc;
    assign write_src  = out_s.write_src;
    assign busy       = out_s.busy;
    assign halted     = out_s.halted;
    assign fault      = out_s.fault;

endmodule

// File: tb/tb_pdp_mc_controller.sv
// Directed bench for pdp_mc_controller (OPW=4, IND_LEVELS=2, WAIT_MAX=15); inputs change
// at the falling edge and outputs are checked 1 time unit later.
module tb_pdp_mc_controller;

    logic       clk = 1'b0;
    logic       rst, start, i_bit, ind_chain, hlt_bit, mem_ready;
    logic [3:0] op;
    logic       mem_read, mem_write, ld_ir, ld_ea, ea_src, ld_mdr, alu_src_a;
    logic       ld_pc, ld_pc_cond, ld_acc, ld_cy, clr_acc, busy, halted, fault;
    logic [1:0] mem_src, alu_src_b, alu_fnc, pc_src, write_src;
    logic [24:0] outs;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pdp_mc_controller #(.OPW(4), .IND_LEVELS(2), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .i_bit(i_bit),
        .ind_chain(ind_chain), .hlt_bit(hlt_bit), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_src(mem_src),
        .ld_ir(ld_ir), .ld_ea(ld_ea), .ea_src(ea_src), .ld_mdr(ld_mdr),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_fnc(alu_fnc),
        .ld_pc(ld_pc), .pc_src(pc_src), .ld_pc_cond(ld_pc_cond),
        .ld_acc(ld_acc), .ld_cy(ld_cy), .clr_acc(clr_acc), .write_src(write_src),
        .busy(busy), .halted(halted), .fault(fault)
    );

    assign outs = {mem_read, mem_write, mem_src, ld_ir, ld_ea, ea_src, ld_mdr, alu_src_a,
                   alu_src_b, alu_fnc, ld_pc, pc_src, ld_pc_cond, ld_acc, ld_cy, clr_acc,
                   write_src, busy, halted, fault};

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; i_bit = 1'b0;
        ind_chain = 1'b0; hlt_bit = 1'b0; op = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse start from IDLE; returns at the first negedge in FETCH, 1 unit after it
    task automatic launch(input logic [3:0] op_v, input logic ib, input logic rdy);
        op = op_v; i_bit = ib; mem_ready = rdy; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mem_ready = 1'b1; op = 4'd1;
        i_bit = 1'b0; ind_chain = 1'b0; hlt_bit = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (outs !== 25'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (outs !== 25'd0) begin failures++; $display("FAIL idle_outs got=%h exp=0", outs); end
    endtask

    task automatic test_tad();
        int acc_n = 0;
        int cy_n = 0;
        int dec_ok = 0;
        apply_reset();
        op = 4'd1; i_bit = 1'b0; mem_ready = 1'b1; start = 1'b1; #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL tad_idle_busy got=%b exp=0", busy); end
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if ({busy, mem_read, mem_src, ld_ir} !== 5'b11001) begin
            failures++; $display("FAIL tad_fetch got=%b exp=11001", {busy, mem_read, mem_src, ld_ir});
        end
        for (int i = 0; i < 3; i++) begin
            acc_n += int'(ld_acc);
            cy_n  += int'(ld_cy);
            if (i == 1 && {ld_pc, pc_src, ld_ea, ea_src, mem_read} == 6'b100100) dec_ok++;
            if (i == 2 && {mem_read, mem_src, alu_fnc} == 5'b10101) dec_ok++;
            @(negedge clk); #1;
        end
        checks++;
        if (dec_ok !== 2) begin failures++; $display("FAIL tad_decode_exec got=%0d exp=2", dec_ok); end
        checks++;
        if (acc_n !== 1 || cy_n !== 1) begin
            failures++; $display("FAIL tad_pulses got acc=%0d cy=%0d exp 1/1", acc_n, cy_n);
        end
        checks++;
        if ({mem_read, mem_src, ld_ir} !== 4'b1001) begin
            failures++; $display("FAIL tad_refetch got=%b exp=1001", {mem_read, mem_src, ld_ir});
        end
    endtask

    task automatic test_isz();
        int rd_n = 0;
        int mdr_n = 0;
        apply_reset();
        launch(4'd2, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            rd_n  += int'(mem_read);
            mdr_n += int'(ld_mdr);
            @(negedge clk);
        end
        #1;
        checks++;
        if (rd_n !== 4 || mdr_n !== 1) begin
            failures++; $display("FAIL isz_wait got rd=%0d mdr=%0d exp 4/1", rd_n, mdr_n);
        end
        checks++;
        if ({mem_write, mem_src, write_src, alu_fnc, ld_pc_cond} !== 8'b10110101) begin
            failures++;
            $display("FAIL isz_exec2 got=%b exp=10110101", {mem_write, mem_src, write_src, alu_fnc, ld_pc_cond});
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_read, ld_ir, mem_write} !== 3'b110) begin
            failures++; $display("FAIL isz_refetch got=%b exp=110", {mem_read, ld_ir, mem_write});
        end
    endtask

    task automatic test_jms_iot();
        apply_reset();
        launch(4'd4, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({mem_write, mem_src, write_src} !== 5'b10101) begin
            failures++; $display("FAIL jms_exec1 got=%b exp=10101", {mem_write, mem_src, write_src});
        end
        @(negedge clk); #1;
        checks++;
        if ({ld_pc, pc_src, mem_write} !== 4'b1100) begin
            failures++; $display("FAIL jms_exec2 got=%b exp=1100", {ld_pc, pc_src, mem_write});
        end
        apply_reset();
        launch(4'd6, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({mem_read, mem_src, ld_ir} !== 4'b1001) begin
            failures++; $display("FAIL iot_refetch got=%b exp=1001", {mem_read, mem_src, ld_ir});
        end
    endtask

    task automatic test_indirect();
        int ea_n = 0;
        int rd_n = 0;
        int fc_n = 0;
        apply_reset();
        launch(4'd5, 1'b1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ind_chain = (i == 0); #1;
            if (ld_ea && ea_src) ea_n++;
            if (mem_read && mem_src == 2'b01) rd_n++;
        end
        @(negedge clk); #1;
        checks++;
        if (ea_n !== 2 || rd_n !== 2) begin
            failures++; $display("FAIL ind_reads got ea=%0d rd=%0d exp 2/2", ea_n, rd_n);
        end
        checks++;
        if ({ld_pc, pc_src, mem_read} !== 4'b1010) begin
            failures++; $display("FAIL ind_jmp got=%b exp=1010", {ld_pc, pc_src, mem_read});
        end
        apply_reset();
        ind_chain = 1'b1;
        launch(4'd5, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk); #1; fc_n += int'(fault);
        @(negedge clk); #1; fc_n += int'(fault);
        checks++;
        if (fc_n !== 0) begin failures++; $display("FAIL ind_early_fault got=%0d exp=0", fc_n); end
        @(negedge clk); #1;
        checks++;
        if ({fault, busy} !== 2'b10) begin failures++; $display("FAIL ind_depth_fault got=%b exp=10", {fault, busy}); end
        for (int i = 0; i < 4; i++) begin
            start = (i % 2 == 0);
            @(negedge clk); #1;
            fc_n += int'(fault);
        end
        start = 1'b0;
        checks++;
        if (fc_n !== 4) begin failures++; $display("FAIL fault_sticky got=%0d exp=4", fc_n); end
    endtask

    task automatic test_timeout();
        int first = -1;
        int ir_n = 0;
        apply_reset();
        launch(4'd1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            ir_n += int'(ld_ir);
            if (fault && first < 0) first = i;
        end
        checks++;
        if (first !== 16 || ir_n !== 0) begin
            failures++; $display("FAIL timeout got cycle=%0d ld_ir=%0d exp 16/0", first, ir_n);
        end
        apply_reset();
        launch(4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) @(negedge clk);
        mem_ready = 1'b1; #1;
        checks++;
        if ({ld_ir, fault} !== 2'b10) begin failures++; $display("FAIL ready_at_max got=%b exp=10", {ld_ir, fault}); end
        @(negedge clk); #1;
        checks++;
        if ({ld_pc, ld_ea, fault} !== 3'b110) begin
            failures++; $display("FAIL ready_at_max_decode got=%b exp=110", {ld_pc, ld_ea, fault});
        end
    endtask

    task automatic test_halt_illegal();
        apply_reset();
        hlt_bit = 1'b1;
        launch(4'd7, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({ld_acc, alu_fnc, mem_read} !== 4'b1110) begin
            failures++; $display("FAIL opr_exec got=%b exp=1110", {ld_acc, alu_fnc, mem_read});
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({halted, busy, mem_read} !== 3'b100) begin
            failures++; $display("FAIL halt_state got=%b exp=100", {halted, busy, mem_read});
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if ({mem_read, halted, busy} !== 3'b101) begin
            failures++; $display("FAIL halt_resume got=%b exp=101", {mem_read, halted, busy});
        end
        apply_reset();
        launch(4'd9, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({fault, busy} !== 2'b10) begin failures++; $display("FAIL illegal_op got=%b exp=10", {fault, busy}); end
    endtask

    task automatic test_reset_mid_dca();
        apply_reset();
        launch(4'd3, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk);
        mem_ready = 1'b0; #1;
        checks++;
        if ({mem_write, mem_src, write_src, clr_acc} !== 6'b101000) begin
            failures++; $display("FAIL dca_wait got=%b exp=101000", {mem_write, mem_src, write_src, clr_acc});
        end
        @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if (outs !== 25'd0) begin failures++; $display("FAIL dca_in_reset got=%h exp=0", outs); end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1; #1;
        checks++;
        if (outs !== 25'd0) begin failures++; $display("FAIL dca_after_reset got=%h exp=0", outs); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; op = 4'd0;
        i_bit = 1'b0; ind_chain = 1'b0; hlt_bit = 1'b0;
        test_reset();
        test_tad();
        test_isz();
        test_jms_iot();
        test_indirect();
        test_timeout();
        test_halt_illegal();
        test_reset_mid_dca();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
